// File: rtl/pc11_rdr_feeder.sv
`timescale 1ns/1ps
// pc11_rdr_feeder
// Feeds paper-tape bytes to the reader half of the pc11 emulation. ARM
// software queues bytes in a small circular FIFO. Whenever the PDP sets
// reader BUSY, the feeder waits one character time. It then writes the next
// byte into pc11 RBUF with DONE set and BUSY cleared. If the tape has run out
// (FIFO empty and eof flagged), it writes the RCSR error bit instead.
//
// Ports:
//   i_clk, i_rst_n      system clock, synchronous active-low reset
//   i_armwrite          ARM write strobe for the feeder registers
//   i_armwaddr          ARM write register select (0..3)
//   i_armwdata          ARM write data
//   i_armraddr          ARM read register select (0..3)
//   o_armrdata          ARM read data (combinational)
//   o_pc_armwrite       one-cycle write strobe into the pc11 ARM port
//   o_pc_armwaddr       pc11 register select, always RBUF/RCSR word (1)
//   o_pc_armraddr       pc11 read select, always RBUF/RCSR word (1)
//   o_pc_armwdata       word written to pc11: [23:16] byte, [15] error,
//                       [11] busy, [7] done, [0] start
//   i_pc_armrdata       pc11 read data: [15] error, [11] busy, [7] done
module pc11_rdr_feeder #(
  parameter int DEPTH   = 16,
  parameter int CHARCYC = 333333
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_armwrite,
  input  logic [1:0]  i_armraddr,
  input  logic [1:0]  i_armwaddr,
  input  logic [31:0] i_armwdata,
  output logic [31:0] o_armrdata,
  output logic        o_pc_armwrite,
  output logic [1:0]  o_pc_armwaddr,
  output logic [1:0]  o_pc_armraddr,
  output logic [31:0] o_pc_armwdata,
  input  logic [31:0] i_pc_armrdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_WRITE  = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_enable;
  logic          r_eof;
  logic          r_ovf;
  logic [31:0]   r_delay;
  logic          r_errForm;
  logic [31:0]   r_lastData;

  logic          w_reg1Wr;
  logic          w_flush;
  logic          w_pushReq;
  logic          w_push;
  logic          w_pop;
  logic          w_drop;
  logic          w_empty;
  logic          w_full;
  logic          w_pcBusy;
  logic          w_pcDone;
  logic          w_delayDone;
  logic [7:0]    w_headByte;
  logic [31:0]   w_writeWord;
  logic [31:0]   w_stat;
  logic          w_unused;

  assign w_reg1Wr    = i_armwrite && (i_armwaddr == 2'd1);
  // Flush beats push issued in the same register write.
  assign w_flush     = w_reg1Wr & i_armwdata[10];
  assign w_pushReq   = w_reg1Wr & i_armwdata[8] & ~w_flush;
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_pcBusy    = i_pc_armrdata[11];
  assign w_pcDone    = i_pc_armrdata[7];
  assign w_delayDone = (r_delay == 32'd0);
  assign w_headByte  = r_mem[r_head];

  // Pop only on a data-form write; a flush landing in that same cycle wins.
  assign w_pop  = (r_state == ST_WRITE) & ~r_errForm & ~w_empty & ~w_flush;
  // A simultaneous pop frees a slot, so a push at full is still accepted.
  assign w_push = w_pushReq & (~w_full | w_pop);
  assign w_drop = w_pushReq & w_full & ~w_pop;

  assign w_unused = &{1'b0, i_pc_armrdata[31:12], i_pc_armrdata[10:8],
                      i_pc_armrdata[6:0], i_armwdata[30:12]};

  // FIFO storage has no reset; validity is tracked by the count/pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_tail] <= i_armwdata[7:0];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Software-visible control flags. A fresh overflow outranks a clear
  // request in the same cycle so that no drop goes unreported.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_enable <= 1'b0;
      r_eof    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_reg1Wr) begin
        r_enable <= i_armwdata[31];
      end
      if (w_flush) begin
        r_eof <= 1'b0;
        r_ovf <= 1'b0;
      end else begin
        if (w_reg1Wr && i_armwdata[9]) begin
          r_eof <= 1'b1;
        end
        if (w_drop) begin
          r_ovf <= 1'b1;
        end else if (w_reg1Wr && i_armwdata[11]) begin
          r_ovf <= 1'b0;
        end
      end
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FSM next state. An abort (busy dropped or feeder disabled) outranks an
  // expiring delay. An empty FIFO without eof parks in DELAY at zero.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (r_enable && w_pcBusy && !w_pcDone) begin
          w_nextState = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (!w_pcBusy || !r_enable) begin
          w_nextState = ST_IDLE;
        end else if (w_delayDone && (!w_empty || r_eof)) begin
          w_nextState = ST_WRITE;
        end
      end
      ST_WRITE:  w_nextState = ST_SETTLE;
      ST_SETTLE: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Character-time counter: loaded on entry to DELAY, counts down, and
  // rests at zero while waiting for data.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_delay <= 32'd0;
    end else if (r_state == ST_IDLE && w_nextState == ST_DELAY) begin
      r_delay <= 32'(CHARCYC - 1);
    end else if (r_state == ST_DELAY && !w_delayDone) begin
      r_delay <= r_delay - 32'd1;
    end
  end

  // The data/error form is frozen when leaving DELAY. A push landing in
  // the WRITE cycle then cannot turn an out-of-tape report into a data
  // write.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_errForm <= 1'b0;
    end else if (r_state == ST_DELAY && w_nextState == ST_WRITE) begin
      r_errForm <= w_empty;
    end
  end

  // The last word written stays on the pc11 data bus between writes.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lastData <= 32'd0;
    end else if (r_state == ST_WRITE) begin
      r_lastData <= w_writeWord;
    end
  end

  // FSM outputs toward the pc11 ARM port.
  always_comb begin
    w_writeWord   = r_errForm ? 32'h0000_8000
                              : {8'h00, w_headByte, 8'h00, 8'h80};
    o_pc_armwrite = (r_state == ST_WRITE);
    o_pc_armwdata = (r_state == ST_WRITE) ? w_writeWord : r_lastData;
    o_pc_armwaddr = 2'd1;
    o_pc_armraddr = 2'd1;
  end

  // ARM register readback.
  always_comb begin
    w_stat          = 32'd0;
    w_stat[CW-1:0]  = r_count;
    w_stat[8]       = w_empty;
    w_stat[9]       = w_full;
    w_stat[10]      = r_eof;
    w_stat[11]      = r_ovf;
    w_stat[13:12]   = r_state;
    w_stat[31]      = r_enable;
    case (i_armraddr)
      2'd0:    o_armrdata = 32'h5046_1002;
      2'd1:    o_armrdata = w_stat;
      2'd2:    o_armrdata = r_delay;
      default: o_armrdata = 32'd0;
    endcase
  end

endmodule

// File: doc/pc11_rdr_feeder.md
Name: pc11_rdr_feeder

Overview:
- Upstream feeder for the pc11 paper-tape reader half.
- ARM software pushes tape bytes into a 16-entry FIFO.
- The block watches the pc11 reader CSR. When the PDP sets reader busy, the block waits one character time, then writes the next byte into pc11 RBUF with DONE set and BUSY cleared.
- It is the sole master of the pc11 ARM register port. It also signals out-of-tape through the RCSR error bit.

Parameters:
- DEPTH, 16: FIFO entries, power of two.
- CHARCYC, 333333: CLOCK cycles per character (300 ch/s at 100 MHz); minimum 1.

Ports:
- CLOCK  in  1  system clock.
- RESET_N  in  1  synchronous active-low reset.
- armwrite  in  1  ARM write strobe for feeder registers.
- armraddr  in  2  ARM read register select.
- armwaddr  in  2  ARM write register select.
- armwdata  in  32  ARM write data.
- armrdata  out  32  ARM read data, combinational mux.
- pc_armwrite  out  1  write strobe to pc11 ARM port.
- pc_armwaddr  out  2  constant 1 (pc11 RBUF/RCSR word).
- pc_armraddr  out  2  constant 1.
- pc_armwdata  out  32  data to pc11.
  - [23:16] byte, [15] error, [11] busy, [7] done, [0] start; all other bits 0.
- pc_armrdata  in  32  pc11 read data.
  - [11] busy, [7] done, [15] error.

Behaviour:
- Reset (RESET_N=0 at CLOCK edge):
  - FIFO empty; count=0.
  - enable=0, eof=0, ovf=0.
  - State IDLE, delay counter 0.
  - pc_armwrite=0, pc_armwdata=0.
- ARM register map, reads:
  - Reg 0: 32'h50461002 ('PF', 2^2 regs, version 002).
  - Reg 1: [4:0] count, [8] empty, [9] full, [10] eof, [11] ovf, [13:12] state, [31] enable.
  - Reg 2: [31:0] delay counter.
  - Reg 3: 32'h0.
- ARM register map, writes:
  - Reg 1 write effects:
    - [8]=1: push [7:0].
    - [9]=1: set eof.
    - [10]=1: flush (count=0, eof=0, ovf=0).
    - [11]=1: clear ovf.
    - [31]: enable.
  - Flush wins over push in the same write.
  - Reg 0, 2, 3 writes are ignored.
- FIFO rules:
  - Circular, DEPTH entries, wrap-around pointers, 5-bit count.
  - Push when count==DEPTH with no pop that cycle: byte dropped, ovf<=1.
  - Push and pop in the same cycle: both occur, count unchanged (legal at full).
  - Pop never occurs when empty.
- States:
  - IDLE (0): if enable & pc busy=1 & pc done=0 -> DELAY, counter<=CHARCYC-1.
  - DELAY (1): counter decrements each cycle.
    - If pc busy drops (PDP init or bus write), or enable=0 -> IDLE, no pop.
    - At counter==0 with FIFO non-empty -> WRITE.
    - At counter==0 with FIFO empty and eof=1 -> WRITE (error form).
    - At counter==0 with FIFO empty and eof=0: stay, counter held at 0, waiting for data.
  - WRITE (2): pc_armwrite=1 for exactly this one cycle.
    - Data form: byte=FIFO head, error 0, busy 0, done 1, start 0; pop same cycle.
    - Error form: byte 00, error 1, busy 0, done 0, start 0; eof remains set.
    - Data/error choice is made from FIFO state at entry to WRITE.
    - -> SETTLE.
  - SETTLE (3): one cycle so pc11 CSR update is visible -> IDLE.
    - Prevents re-triggering on stale busy.
- Outside WRITE: pc_armwrite=0; pc_armwdata holds last value.
- Latency: pc busy seen -> pc_armwrite asserts after CHARCYC+1 cycles when data is present.
- Reset mid-DELAY or mid-WRITE: returns to IDLE and clears the FIFO. Any pc_armwrite in flight deasserts on that edge.

Test Plan:
- Reset, then read reg 0 -> 32'h50461002. Read reg 1 -> empty=1, count=0, state=0.
- CHARCYC=4. Enable; push 8'o123. Hold pc busy=1/done=0 -> pc_armwrite pulses one cycle, exactly 5 cycles after busy, with pc_armwdata=32'h00530080. Count then reads 0.
- Push 17 bytes with no busy -> count=16, full=1, ovf=1. First 16 bytes emerge in order on successive busy cycles.
- FIFO empty, eof set, busy=1 -> after CHARCYC a write with pc_armwdata=32'h00008000. eof is still 1 afterwards.
- Busy=1, then busy drops to 0 mid-DELAY -> state IDLE, no pc_armwrite, count unchanged.
- Full FIFO in WRITE with an ARM push in the same cycle -> count stays 16, ovf stays 0, pushed byte appears last.
